// File: rtl/hook_pkg.sv
// rtl/hook_pkg.sv - shared types and helpers for the hook sequencer
package hook_pkg;

   localparam int WEIGHT_W = 2;

   typedef enum logic [2:0] {
      ST_SWING          = 3'd0,
      ST_EXTEND         = 3'd1,
      ST_RETRACT_EMPTY  = 3'd2,
      ST_RETRACT_LOADED = 3'd3,
      ST_COLLECT        = 3'd4
   } hook_state_t;

   // Heavier objects slow the hook: base speed halved per weight class, never below 1.
   function automatic logic [15:0] retract_step(input logic [15:0] base,
                                               input logic [WEIGHT_W-1:0] weight);
      logic [15:0] s;
      s = base >> weight;
      if (s == 16'd0) s = 16'd1;
      return s;
   endfunction

endpackage

// File: rtl/frame_event_latch.sv
// rtl/frame_event_latch.sv - first-event-per-frame capture with optional payload
module frame_event_latch #(
   parameter int PAYLOAD_W = 0,
   localparam int PW = (PAYLOAD_W > 0) ? PAYLOAD_W : 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          sof_i,
   input  logic          strobe_i,
   input  logic [PW-1:0] payload_i,
   output logic          valid_o,
   output logic [PW-1:0] payload_o
);

   logic valid_q, valid_d;
   logic capture;

   // A strobe on the start-of-frame cycle belongs to the new frame, so it wins over the clear.
   assign capture = strobe_i & (sof_i | ~valid_q);
   assign valid_d = sof_i ? strobe_i : (valid_q | strobe_i);
   assign valid_o = valid_q;

   // Semaphore bit: set by the first strobe, cleared at frame start.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) valid_q <= 1'b0;
      else       valid_q <= valid_d;
   end

   generate
      if (PAYLOAD_W > 0) begin : g_payload
         logic [PW-1:0] payload_q;
         // Payload is frozen after the first capture of the frame.
         always_ff @(posedge clk or posedge reset) begin
            if (reset)        payload_q <= '0;
            else if (capture) payload_q <= payload_i;
         end
         assign payload_o = payload_q;
      end else begin : g_no_payload
         assign payload_o = '0;
      end
   endgenerate

endmodule

// File: rtl/hook_sequencer.sv
// rtl/hook_sequencer.sv - frame-rate hook state machine for the Gold Miner game
module hook_sequencer
   import hook_pkg::*;
#(
   parameter int LEN_W          = 9,
   parameter int MAX_LEN        = 400,
   parameter int EXT_SPEED      = 8,
   parameter int RETRACT_SPEED  = 8,
   parameter int ID_W           = 4,
   parameter int COLLECT_FRAMES = 15
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            startOfFrame,
   input  logic            launch,
   input  logic            collision_hook_object,
   input  logic [ID_W-1:0] hit_id,
   input  logic [1:0]      hit_weight,
   input  logic [7:0]      hit_value,
   input  logic            collision_hook_border,
   output logic [LEN_W-1:0] hook_len,
   output logic [2:0]       hook_state,
   output logic             swing_enable,
   output logic             grab_pulse,
   output logic [ID_W-1:0]  grab_id,
   output logic             score_valid,
   output logic [7:0]       score_add
);

   localparam int OBJ_W = ID_W + WEIGHT_W + 8;
   localparam int CNT_W = $clog2(COLLECT_FRAMES + 1);

   generate
      if (MAX_LEN >= (1 << LEN_W)) begin : g_len_check
         $error("MAX_LEN does not fit in LEN_W bits");
      end
   endgenerate

   // Event latches for the frame in progress
   logic             obj_valid;
   logic [OBJ_W-1:0] obj_payload;
   logic             border_valid;
   logic             border_payload;

   frame_event_latch #(.PAYLOAD_W(OBJ_W)) u_obj_latch (
      .clk       (clk),
      .reset     (reset),
      .sof_i     (startOfFrame),
      .strobe_i  (collision_hook_object),
      .payload_i ({hit_id, hit_weight, hit_value}),
      .valid_o   (obj_valid),
      .payload_o (obj_payload)
   );

   frame_event_latch #(.PAYLOAD_W(0)) u_border_latch (
      .clk       (clk),
      .reset     (reset),
      .sof_i     (startOfFrame),
      .strobe_i  (collision_hook_border),
      .payload_i (1'b0),
      .valid_o   (border_valid),
      .payload_o (border_payload)
   );

   logic [ID_W-1:0]     obj_id;
   logic [WEIGHT_W-1:0] obj_weight;
   logic [7:0]          obj_value;
   assign obj_id     = obj_payload[OBJ_W-1 -: ID_W];
   assign obj_weight = obj_payload[8 +: WEIGHT_W];
   assign obj_value  = obj_payload[7:0];

   hook_state_t         state_q, state_d;
   logic [LEN_W-1:0]    len_q, len_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [WEIGHT_W-1:0] weight_q, weight_d;
   logic [7:0]          value_q, value_d;
   logic                pending_q, pending_d;
   logic                launch_prev_q;
   logic                grab_pulse_q, grab_pulse_d;
   logic [ID_W-1:0]     grab_id_q, grab_id_d;
   logic                score_valid_q, score_valid_d;
   logic [7:0]          score_add_q, score_add_d;
   logic                swing_en_q, swing_en_d;

   logic             launch_rise;
   logic [LEN_W:0]   len_ext, ext_sum, max_len_w, re_step, rl_step, re_res, rl_res;

   assign launch_rise = launch & ~launch_prev_q;
   assign len_ext     = {1'b0, len_q};
   assign max_len_w   = (LEN_W+1)'(MAX_LEN);
   assign ext_sum     = len_ext + (LEN_W+1)'(EXT_SPEED);
   assign re_step     = (LEN_W+1)'(RETRACT_SPEED);
   assign rl_step     = (LEN_W+1)'(retract_step(16'(RETRACT_SPEED), weight_q));
   assign re_res      = (len_ext > re_step) ? (len_ext - re_step) : '0;
   assign rl_res      = (len_ext > rl_step) ? (len_ext - rl_step) : '0;

   // Next-state and output decode; everything except the launch edge waits for startOfFrame.
   always_comb begin
      state_d       = state_q;
      len_d         = len_q;
      cnt_d         = cnt_q;
      weight_d      = weight_q;
      value_d       = value_q;
      pending_d     = pending_q | launch_rise;
      grab_pulse_d  = 1'b0;
      grab_id_d     = grab_id_q;
      score_valid_d = 1'b0;
      score_add_d   = score_add_q;
      if (startOfFrame) begin
         pending_d = launch_rise;
         unique case (state_q)
            ST_SWING: begin
               if (pending_q) begin
                  state_d = ST_EXTEND;
                  len_d   = '0;
               end
            end
            ST_EXTEND: begin
               if (obj_valid) begin
                  state_d      = ST_RETRACT_LOADED;
                  weight_d     = obj_weight;
                  value_d      = obj_value;
                  grab_pulse_d = 1'b1;
                  grab_id_d    = obj_id;
               end else if (border_valid) begin
                  state_d = ST_RETRACT_EMPTY;
               end else if (ext_sum >= max_len_w) begin
                  state_d = ST_RETRACT_EMPTY;
                  len_d   = LEN_W'(MAX_LEN);
               end else begin
                  len_d = ext_sum[LEN_W-1:0];
               end
            end
            ST_RETRACT_EMPTY: begin
               len_d = re_res[LEN_W-1:0];
               if (re_res == '0) state_d = ST_SWING;
            end
            ST_RETRACT_LOADED: begin
               len_d = rl_res[LEN_W-1:0];
               if (rl_res == '0) begin
                  state_d       = ST_COLLECT;
                  score_valid_d = 1'b1;
                  score_add_d   = value_q;
               end
            end
            ST_COLLECT: begin
               if (cnt_q == CNT_W'(COLLECT_FRAMES - 1)) begin
                  state_d = ST_SWING;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            default: begin
               state_d = ST_SWING;
               len_d   = '0;
               cnt_d   = '0;
            end
         endcase
      end
      swing_en_d = (state_d == ST_SWING);
   end

   // State, hook length and all output registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= ST_SWING;
         len_q         <= '0;
         cnt_q         <= '0;
         weight_q      <= '0;
         value_q       <= '0;
         pending_q     <= 1'b0;
         launch_prev_q <= 1'b0;
         grab_pulse_q  <= 1'b0;
         grab_id_q     <= '0;
         score_valid_q <= 1'b0;
         score_add_q   <= '0;
         swing_en_q    <= 1'b1;
      end else begin
         state_q       <= state_d;
         len_q         <= len_d;
         cnt_q         <= cnt_d;
         weight_q      <= weight_d;
         value_q       <= value_d;
         pending_q     <= pending_d;
         launch_prev_q <= launch;
         grab_pulse_q  <= grab_pulse_d;
         grab_id_q     <= grab_id_d;
         score_valid_q <= score_valid_d;
         score_add_q   <= score_add_d;
         swing_en_q    <= swing_en_d;
      end
   end

   assign hook_len     = len_q;
   assign hook_state   = state_q;
   assign swing_enable = swing_en_q;
   assign grab_pulse   = grab_pulse_q;
   assign grab_id      = grab_id_q;
   assign score_valid  = score_valid_q;
   assign score_add    = score_add_q;

endmodule

// File: tb/tb_hook_sequencer.sv
// tb/tb_hook_sequencer.sv - directed self-checking bench for hook_sequencer
module tb_hook_sequencer;

   logic       clk = 1'b0;
   logic       reset;
   logic       startOfFrame;
   logic       launch;
   logic       collision_hook_object;
   logic [3:0] hit_id;
   logic [1:0] hit_weight;
   logic [7:0] hit_value;
   logic       collision_hook_border;
   logic [8:0] hook_len;
   logic [2:0] hook_state;
   logic       swing_enable;
   logic       grab_pulse;
   logic [3:0] grab_id;
   logic       score_valid;
   logic [7:0] score_add;

   int checks = 0;
   int passes = 0;
   int grab_cnt = 0;
   int score_cnt = 0;

   hook_sequencer dut (
      .clk                   (clk),
      .reset                 (reset),
      .startOfFrame          (startOfFrame),
      .launch                (launch),
      .collision_hook_object (collision_hook_object),
      .hit_id                (hit_id),
      .hit_weight            (hit_weight),
      .hit_value             (hit_value),
      .collision_hook_border (collision_hook_border),
      .hook_len              (hook_len),
      .hook_state            (hook_state),
      .swing_enable          (swing_enable),
      .grab_pulse            (grab_pulse),
      .grab_id               (grab_id),
      .score_valid           (score_valid),
      .score_add             (score_add)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (grab_pulse === 1'b1)  grab_cnt++;
      if (score_valid === 1'b1) score_cnt++;
   end

   task automatic sof_tick();
      @(negedge clk); startOfFrame = 1'b1;
      @(negedge clk); startOfFrame = 1'b0;
   endtask

   task automatic launch_pulse();
      @(negedge clk); launch = 1'b1;
      @(negedge clk); launch = 1'b0;
   endtask

   task automatic obj_hit(input logic [3:0] id, input logic [1:0] w, input logic [7:0] v);
      @(negedge clk);
      collision_hook_object = 1'b1; hit_id = id; hit_weight = w; hit_value = v;
      @(negedge clk);
      collision_hook_object = 1'b0;
   endtask

   task automatic border_hit();
      @(negedge clk); collision_hook_border = 1'b1;
      @(negedge clk); collision_hook_border = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; startOfFrame = 1'b0; launch = 1'b0;
      collision_hook_object = 1'b0; collision_hook_border = 1'b0;
      hit_id = '0; hit_weight = '0; hit_value = '0;
      repeat (3) @(negedge clk);
      checks++; if (hook_state !== 3'd0) $display("FAIL reset_state: got %0d want 0", hook_state); else passes++;
      checks++; if (hook_len !== 9'd0) $display("FAIL reset_len: got %0d want 0", hook_len); else passes++;
      checks++; if ({grab_pulse, score_valid} !== 2'b00) $display("FAIL reset_pulses: got %b want 00", {grab_pulse, score_valid}); else passes++;
      checks++; if ({grab_id, score_add} !== 12'd0) $display("FAIL reset_ids: got %h want 0", {grab_id, score_add}); else passes++;
      checks++; if (swing_enable !== 1'b1) $display("FAIL reset_swing_en: got %b want 1", swing_enable); else passes++;
      @(negedge clk); reset = 1'b0;
   endtask

   task automatic test_full_extend();
      launch_pulse(); sof_tick();
      checks++; if ({hook_state, hook_len, swing_enable} !== {3'd1, 9'd0, 1'b0}) $display("FAIL ext_start: got st=%0d len=%0d se=%b want 1 0 0", hook_state, hook_len, swing_enable); else passes++;
      for (int i = 1; i <= 49; i++) begin
         sof_tick();
         checks++; if ({hook_state, hook_len} !== {3'd1, 9'(8*i)}) $display("FAIL ext_ramp_%0d: got st=%0d len=%0d want 1 %0d", i, hook_state, hook_len, 8*i); else passes++;
      end
      sof_tick();
      checks++; if ({hook_state, hook_len} !== {3'd2, 9'd400}) $display("FAIL ext_max: got st=%0d len=%0d want 2 400", hook_state, hook_len); else passes++;
      for (int k = 1; k <= 49; k++) begin
         sof_tick();
         checks++; if ({hook_state, hook_len} !== {3'd2, 9'(400-8*k)}) $display("FAIL ret_empty_%0d: got st=%0d len=%0d want 2 %0d", k, hook_state, hook_len, 400-8*k); else passes++;
      end
      sof_tick();
      checks++; if ({hook_state, hook_len} !== {3'd0, 9'd0}) $display("FAIL ret_empty_end: got st=%0d len=%0d want 0 0", hook_state, hook_len); else passes++;
      checks++; if ({grab_cnt, score_cnt} !== {32'd0, 32'd0}) $display("FAIL ext_no_pulses: got grabs=%0d scores=%0d want 0 0", grab_cnt, score_cnt); else passes++;
   endtask

   task automatic test_grab();
      int g0, s0;
      g0 = grab_cnt; s0 = score_cnt;
      launch_pulse(); sof_tick();
      repeat (10) sof_tick();
      checks++; if ({hook_state, hook_len} !== {3'd1, 9'd80}) $display("FAIL grab_pre: got st=%0d len=%0d want 1 80", hook_state, hook_len); else passes++;
      obj_hit(4'd5, 2'd2, 8'd50); obj_hit(4'd5, 2'd2, 8'd50); obj_hit(4'd5, 2'd2, 8'd50);
      obj_hit(4'd7, 2'd0, 8'd99);
      sof_tick();
      checks++; if ({hook_state, hook_len} !== {3'd3, 9'd80}) $display("FAIL grab_state: got st=%0d len=%0d want 3 80", hook_state, hook_len); else passes++;
      checks++; if ({grab_pulse, grab_id} !== {1'b1, 4'd5}) $display("FAIL grab_pulse_id: got p=%b id=%0d want 1 5", grab_pulse, grab_id); else passes++;
      @(negedge clk);
      checks++; if (grab_pulse !== 1'b0) $display("FAIL grab_pulse_width: got %b want 0", grab_pulse); else passes++;
      for (int k = 1; k <= 39; k++) begin
         sof_tick();
         checks++; if ({hook_state, hook_len} !== {3'd3, 9'(80-2*k)}) $display("FAIL ret_loaded_%0d: got st=%0d len=%0d want 3 %0d", k, hook_state, hook_len, 80-2*k); else passes++;
      end
      sof_tick();
      checks++; if ({hook_state, hook_len} !== {3'd4, 9'd0}) $display("FAIL collect_entry: got st=%0d len=%0d want 4 0", hook_state, hook_len); else passes++;
      checks++; if ({score_valid, score_add} !== {1'b1, 8'd50}) $display("FAIL score_pulse: got v=%b add=%0d want 1 50", score_valid, score_add); else passes++;
      @(negedge clk);
      checks++; if ({score_valid, score_add} !== {1'b0, 8'd50}) $display("FAIL score_width: got v=%b add=%0d want 0 50", score_valid, score_add); else passes++;
      for (int k = 1; k <= 14; k++) begin
         sof_tick();
         checks++; if (hook_state !== 3'd4) $display("FAIL collect_%0d: got st=%0d want 4", k, hook_state); else passes++;
      end
      sof_tick();
      checks++; if ({hook_state, swing_enable} !== {3'd0, 1'b1}) $display("FAIL collect_exit: got st=%0d se=%b want 0 1", hook_state, swing_enable); else passes++;
      checks++; if ({grab_cnt - g0, score_cnt - s0} !== {32'd1, 32'd1}) $display("FAIL grab_counts: got grabs=%0d scores=%0d want 1 1", grab_cnt - g0, score_cnt - s0); else passes++;
      checks++; if (grab_id !== 4'd5) $display("FAIL grab_id_hold: got %0d want 5", grab_id); else passes++;
   endtask

   task automatic test_obj_border();
      launch_pulse(); sof_tick();
      repeat (3) sof_tick();
      obj_hit(4'd9, 2'd3, 8'd20); border_hit();
      sof_tick();
      checks++; if ({hook_state, hook_len, grab_id} !== {3'd3, 9'd24, 4'd9}) $display("FAIL ob_priority: got st=%0d len=%0d id=%0d want 3 24 9", hook_state, hook_len, grab_id); else passes++;
      sof_tick();
      checks++; if ({hook_state, hook_len} !== {3'd3, 9'd23}) $display("FAIL ob_step_clamp: got st=%0d len=%0d want 3 23", hook_state, hook_len); else passes++;
      repeat (22) sof_tick();
      checks++; if ({hook_state, hook_len} !== {3'd3, 9'd1}) $display("FAIL ob_len1: got st=%0d len=%0d want 3 1", hook_state, hook_len); else passes++;
      sof_tick();
      checks++; if ({hook_state, score_valid, score_add} !== {3'd4, 1'b1, 8'd20}) $display("FAIL ob_score: got st=%0d v=%b add=%0d want 4 1 20", hook_state, score_valid, score_add); else passes++;
      repeat (15) sof_tick();
      checks++; if (hook_state !== 3'd0) $display("FAIL ob_swing: got st=%0d want 0", hook_state); else passes++;
   endtask

   task automatic test_sof_strobe();
      launch_pulse(); sof_tick(); sof_tick();
      @(negedge clk);
      startOfFrame = 1'b1; collision_hook_object = 1'b1; hit_id = 4'd3; hit_weight = 2'd0; hit_value = 8'd11;
      @(negedge clk);
      startOfFrame = 1'b0; collision_hook_object = 1'b0;
      checks++; if ({hook_state, hook_len, grab_pulse} !== {3'd1, 9'd16, 1'b0}) $display("FAIL sofs_not_now: got st=%0d len=%0d p=%b want 1 16 0", hook_state, hook_len, grab_pulse); else passes++;
      sof_tick();
      checks++; if ({hook_state, hook_len, grab_pulse, grab_id} !== {3'd3, 9'd16, 1'b1, 4'd3}) $display("FAIL sofs_next: got st=%0d len=%0d p=%b id=%0d want 3 16 1 3", hook_state, hook_len, grab_pulse, grab_id); else passes++;
      sof_tick();
      checks++; if (hook_len !== 9'd8) $display("FAIL sofs_step8: got %0d want 8", hook_len); else passes++;
      sof_tick();
      checks++; if ({hook_state, score_add} !== {3'd4, 8'd11}) $display("FAIL sofs_score: got st=%0d add=%0d want 4 11", hook_state, score_add); else passes++;
      repeat (15) sof_tick();
      checks++; if (hook_state !== 3'd0) $display("FAIL sofs_swing: got st=%0d want 0", hook_state); else passes++;
   endtask

   task automatic test_border();
      launch_pulse(); sof_tick(); sof_tick(); sof_tick();
      border_hit();
      sof_tick();
      checks++; if ({hook_state, hook_len} !== {3'd2, 9'd16}) $display("FAIL border_hit: got st=%0d len=%0d want 2 16", hook_state, hook_len); else passes++;
      sof_tick();
      checks++; if ({hook_state, hook_len} !== {3'd2, 9'd8}) $display("FAIL border_ret: got st=%0d len=%0d want 2 8", hook_state, hook_len); else passes++;
      sof_tick();
      checks++; if ({hook_state, hook_len} !== {3'd0, 9'd0}) $display("FAIL border_swing: got st=%0d len=%0d want 0 0", hook_state, hook_len); else passes++;
   endtask

   task automatic test_launch_hold();
      @(negedge clk); launch = 1'b1;
      sof_tick();
      checks++; if (hook_state !== 3'd1) $display("FAIL hold_launch: got st=%0d want 1", hook_state); else passes++;
      border_hit();
      sof_tick();
      checks++; if ({hook_state, hook_len} !== {3'd2, 9'd0}) $display("FAIL hold_border0: got st=%0d len=%0d want 2 0", hook_state, hook_len); else passes++;
      sof_tick();
      checks++; if (hook_state !== 3'd0) $display("FAIL hold_back: got st=%0d want 0", hook_state); else passes++;
      for (int k = 1; k <= 4; k++) begin
         sof_tick();
         checks++; if (hook_state !== 3'd0) $display("FAIL hold_no_relaunch_%0d: got st=%0d want 0", k, hook_state); else passes++;
      end
      @(negedge clk); launch = 1'b0;
      launch_pulse(); sof_tick(); sof_tick();
      border_hit();
      sof_tick();
      checks++; if ({hook_state, hook_len} !== {3'd2, 9'd8}) $display("FAIL retract_press_pre: got st=%0d len=%0d want 2 8", hook_state, hook_len); else passes++;
      launch_pulse();
      sof_tick();
      checks++; if (hook_state !== 3'd0) $display("FAIL retract_press_swing: got st=%0d want 0", hook_state); else passes++;
      sof_tick();
      checks++; if (hook_state !== 3'd0) $display("FAIL retract_press_discard: got st=%0d want 0", hook_state); else passes++;
   endtask

   task automatic test_mid_reset();
      launch_pulse(); sof_tick();
      repeat (15) sof_tick();
      checks++; if ({hook_state, hook_len} !== {3'd1, 9'd120}) $display("FAIL mr_pre: got st=%0d len=%0d want 1 120", hook_state, hook_len); else passes++;
      obj_hit(4'd4, 2'd1, 8'd7);
      @(negedge clk); startOfFrame = 1'b1; reset = 1'b1;
      @(negedge clk); startOfFrame = 1'b0; reset = 1'b0;
      checks++; if ({hook_state, hook_len} !== {3'd0, 9'd0}) $display("FAIL mr_state: got st=%0d len=%0d want 0 0", hook_state, hook_len); else passes++;
      checks++; if ({grab_pulse, score_valid, grab_id} !== {1'b0, 1'b0, 4'd0}) $display("FAIL mr_pulse: got p=%b v=%b id=%0d want 0 0 0", grab_pulse, score_valid, grab_id); else passes++;
      @(negedge clk);
      checks++; if (grab_pulse !== 1'b0) $display("FAIL mr_pulse_late: got %b want 0", grab_pulse); else passes++;
      sof_tick();
      checks++; if (hook_state !== 3'd0) $display("FAIL mr_no_relaunch: got st=%0d want 0", hook_state); else passes++;
   endtask

   initial begin
      test_reset();
      test_full_extend();
      test_grab();
      test_obj_border();
      test_sof_strobe();
      test_border();
      test_launch_hold();
      test_mid_reset();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
